// File: rtl/mips32_pkg.sv
// Shared MIPS32 definitions used by the fetch front end: opcode map,
// default instruction-memory address width and fetch FSM encoding.
package mips32_pkg;

    localparam int AW_DEFAULT = 10;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_HLT   = 6'b111111;

    localparam logic [5:0] FN_ADD   = 6'b100000;

    typedef enum logic {
        FS_RUN  = 1'b0,
        FS_STOP = 1'b1
    } fetch_state_e;

    function automatic logic is_hlt(input logic [31:0] ir);
        return ir[31:26] == OP_HLT;
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// First-word-fall-through instruction queue; head entry is visible on rdata
// combinationally whenever count is non-zero.
module ifetch_fifo
    import mips32_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 32 + AW_DEFAULT
) (
    input  logic                   clk1,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [W-1:0]           wdata,
    input  logic                   pop,
    output logic [W-1:0]           rdata,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          do_push, do_pop;

    always_comb begin
        do_push  = push & ~flush;
        do_pop   = pop & (count_q != '0) & ~flush;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        // A flush drops everything, including a pop presented in the same cycle.
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk1) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/ifetch_buffer.sv
// Instruction fetch front end: run/stop FSM, PC, single-outstanding read
// tracking with squash, and credit-based issue into the FWFT queue.
module ifetch_buffer
    import mips32_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter int              AW       = AW_DEFAULT,
    parameter logic [AW-1:0]   RESET_PC = '0
) (
    input  logic          clk1,
    input  logic          rst,
    output logic          imem_en,
    output logic [AW-1:0] imem_addr,
    input  logic [31:0]   imem_rdata,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    input  logic          halt,
    output logic          id_valid,
    input  logic          id_ready,
    output logic [31:0]   id_ir,
    output logic [31:0]   id_npc,
    output logic          stopped
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = 32 + AW;

    fetch_state_e  state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic          inflight_q, inflight_d;
    logic [AW-1:0] inflight_addr_q, inflight_addr_d;

    logic [CW-1:0] fifo_count;
    logic [EW-1:0] fifo_rdata;
    logic [EW-1:0] push_data;
    logic [CW-1:0] occ;
    logic          pop, push, hlt_push;

    always_comb begin
        pop       = id_valid & id_ready;
        // Occupancy the queue would reach if this cycle's read lands next cycle.
        occ       = fifo_count + CW'(inflight_q) - CW'(pop);
        imem_en   = ~rst && (state_q == FS_RUN) && ~redirect_valid && (occ < CW'(DEPTH));
        imem_addr = pc_q;

        push      = inflight_q & ~redirect_valid;
        push_data = {imem_rdata, inflight_addr_q};
        hlt_push  = push & is_hlt(imem_rdata);

        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (imem_en) begin
            pc_d = pc_q + AW'(1);
        end

        // A read issued alongside a HLT push is squashed before it lands.
        inflight_d      = imem_en & ~hlt_push;
        inflight_addr_d = imem_en ? pc_q : inflight_addr_q;

        state_d = state_q;
        case (state_q)
            FS_RUN:  if (halt || hlt_push) state_d = FS_STOP;
            FS_STOP: if (redirect_valid && !halt) state_d = FS_RUN;
        endcase
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q         <= FS_RUN;
            pc_q            <= RESET_PC;
            inflight_q      <= 1'b0;
            inflight_addr_q <= '0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            inflight_q      <= inflight_d;
            inflight_addr_q <= inflight_addr_d;
        end
    end

    ifetch_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk1  (clk1),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (push),
        .wdata (push_data),
        .pop   (pop),
        .rdata (fifo_rdata),
        .count (fifo_count)
    );

    assign id_valid = (fifo_count != '0);
    assign id_ir    = fifo_rdata[EW-1:AW];
    assign id_npc   = 32'(fifo_rdata[AW-1:0]) + 32'd1;
    assign stopped  = (state_q == FS_STOP);

endmodule

// File: doc/ifetch_buffer.md
IFETCH_BUFFER -- requirements
Module: ifetch_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of instruction-queue entries (power of two, >=2).
REQ-002 Parameter AW, default 10, instruction-memory word-address width (1024-word memory).
REQ-003 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-004 clk1  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 imem_en  output  1  read strobe to instruction memory.
REQ-007 imem_addr  output  AW  word address of the read.
REQ-008 imem_rdata  input  32  read data, valid exactly one cycle after imem_en.
REQ-009 redirect_valid  input  1  taken branch from EX; flush and refetch.
REQ-010 redirect_pc  input  AW  branch target word address.
REQ-011 halt  input  1  external stop-fetch request, level-sensitive.
REQ-012 id_valid  output  1  queue head holds an instruction for decode.
REQ-013 id_ready  input  1  decode accepts head this cycle.
REQ-014 id_ir  output  32  head instruction word.
REQ-015 id_npc  output  32  head fetch address + 1, zero-extended to 32 bits.
REQ-016 stopped  output  1  fetch FSM is in STOP.

Function
REQ-017 Fetch FSM has two states: RUN (issuing permitted) and STOP (no new reads).
REQ-018 RUN->STOP when halt=1, or when a pushed word has opcode [31:26]=6'b111111 (HLT).
REQ-019 STOP->RUN only on redirect_valid=1 while halt=0; halt=1 holds STOP even with redirect.
REQ-020 imem_en=1 iff RUN, no redirect this cycle, and count + inflight - pop < DEPTH; pop = id_valid & id_ready.
REQ-021 imem_addr = PC; on issue PC <= PC+1, wrapping 2^AW-1 -> 0.
REQ-022 Response captured the cycle after issue and pushed as {ir=imem_rdata, npc=issued address+1}, unless squashed.
REQ-023 Queue is first-word-fall-through: id_valid = (count != 0); id_ir/id_npc show head combinationally from storage.
REQ-024 Handshake: entry leaves queue only when id_valid & id_ready; head outputs stable while id_valid & !id_ready.
REQ-025 Simultaneous push and pop: count unchanged; push to full queue is impossible by REQ-020.
REQ-026 redirect_valid: queue emptied (count <= 0), pop ignored, any read in flight squashed, PC <= redirect_pc.
REQ-027 First read after redirect issues at redirect_pc in the following cycle (one-cycle bubble).
REQ-028 Halt opcode word is itself pushed and delivered to decode; reads already in flight are squashed.
REQ-029 External halt does not flush: in-flight response still pushed, queue still drains to decode.
REQ-030 Sustained throughput one instruction per cycle while id_ready=1 and RUN.
REQ-031 Fetch-to-id_valid latency: two cycles from imem_en to id_valid on an empty queue.

Reset
REQ-032 On rst=1: PC <= RESET_PC, count <= 0, read/write pointers <= 0, inflight <= 0, FSM <= RUN.
REQ-033 Reset outputs: imem_en=0, id_valid=0, stopped=0; id_ir/id_npc don't-care while id_valid=0.
REQ-034 Reset mid-fetch discards any in-flight response; rst overrides redirect and halt.
REQ-035 First imem_en=1 (address RESET_PC) in the cycle after rst deasserts.

Structure
REQ-036 Opcode constants (HLT=6'b111111 and the processor opcode set) and AW default live in shared package mips32_pkg.
REQ-037 Queue storage/pointers in one sub-module, ifetch_fifo (FWFT, parameter DEPTH, width 32+AW).
REQ-038 FSM, PC, inflight/squash tracking and issue credit in ifetch_buffer top.

Verification
REQ-039 Reset, memory 0..7 = ADD words, id_ready=1 -> imem_addr 0,1,2.. each cycle; id_npc 1,2,3.. back-to-back from cycle 3.
REQ-040 id_ready=0 for 10 cycles -> exactly DEPTH=4 reads issued, imem_en=0 thereafter, id_ir holds address-0 word.
REQ-041 Redirect to 0x100 while queue holds 3 and one read in flight -> id_valid=0 next cycle, in-flight word never delivered, next id_npc=0x101.
REQ-042 HLT word at address 5 -> entries 0..5 delivered, stopped=1, no read of address >=7 delivered; redirect to 0 -> stopped=0, fetch resumes at 0.
REQ-043 RESET_PC=1023 -> fetch order 1023,0,1; id_npc for 1023 equals 0x400 (address+1 zero-extended).
REQ-044 rst asserted with queue full and read in flight -> id_valid=0 next cycle, refetch begins at RESET_PC.
